// File: rtl/memory_access.sv
// memory_access: memory stage of the 64-bit in-order pipeline.
//
// Turns the execute-stage bundle into a data-bus request (load or store).
// It formats the store data and byte strobes for the bus and formats the
// returned load data with sign or zero extension. The result is emitted as
// the memory_data_t bundle that memory_reg latches. While a bus access is
// outstanding it requests a stall. A result that completes while the
// pipeline is not advancing is held until the pipeline advances.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   dataE             execute bundle (pc, result_alu, wd, wa, ctl)
//   advance, flush    pipeline moves this cycle / squash current op
//   dataM             bundle to memory_reg (load data replaces result_alu)
//   stallM_req        hold the pipeline while a bus access is pending
//   misalign          one-cycle pulse on a misaligned access
//   dreq_*            data-bus request (valid, addr, size, strobe, data)
//   dresp_data_ok     completion of the held request
//   dresp_data        raw aligned 8-byte read beat

package memory_access_pkg;
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ALU = 4'd1;
    localparam logic [3:0] OP_LB  = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LD  = 4'd5;
    localparam logic [3:0] OP_LBU = 4'd6;
    localparam logic [3:0] OP_LHU = 4'd7;
    localparam logic [3:0] OP_LWU = 4'd8;
    localparam logic [3:0] OP_SB  = 4'd9;
    localparam logic [3:0] OP_SH  = 4'd10;
    localparam logic [3:0] OP_SW  = 4'd11;
    localparam logic [3:0] OP_SD  = 4'd12;

    typedef struct packed {
        logic [3:0] op;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       nop_signal;
    } ctl_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] result_alu;
        logic [63:0] wd;
        logic [4:0]  wa;
        ctl_t        ctl;
    } execute_data_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] result_alu;
        logic [4:0]  wa;
        ctl_t        ctl;
    } memory_data_t;

    // Bus size code: 0=byte, 1=half, 2=word, 3=double.
    function automatic logic [2:0] op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = 3'd0;
            OP_LH, OP_LHU, OP_SH: op_size = 3'd1;
            OP_LW, OP_LWU, OP_SW: op_size = 3'd2;
            default:              op_size = 3'd3;
        endcase
    endfunction

    // lane already has the addressed byte shifted down to bit 0.
    function automatic logic [63:0] format_load(input logic [3:0] op, input logic [63:0] lane);
        case (op)
            OP_LB:   format_load = {{56{lane[7]}}, lane[7:0]};
            OP_LBU:  format_load = {56'd0, lane[7:0]};
            OP_LH:   format_load = {{48{lane[15]}}, lane[15:0]};
            OP_LHU:  format_load = {48'd0, lane[15:0]};
            OP_LW:   format_load = {{32{lane[31]}}, lane[31:0]};
            OP_LWU:  format_load = {32'd0, lane[31:0]};
            default: format_load = lane;
        endcase
    endfunction
endpackage

module memory_access
    import memory_access_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  execute_data_t     dataE,
    input  logic              advance,
    input  logic              flush,
    output memory_data_t      dataM,
    output logic              stallM_req,
    output logic              misalign,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;

    // Latched copy of the issued request, replayed while WAIT/DRAIN.
    logic [63:0]  r_addr;
    logic [2:0]   r_size;
    logic [7:0]   r_strobe;
    logic [63:0]  r_data;
    memory_data_t r_bundle;

    logic         w_capture;
    logic         w_bundle_we;
    memory_data_t w_bundle_d;

    // Request fields derived from the live execute bundle.
    logic         w_e_is_mem;
    logic [2:0]   w_e_size;
    logic [2:0]   w_e_off;
    logic         w_e_aligned;
    logic [3:0]   w_e_nbytes;
    logic [7:0]   w_e_strobe;
    logic [63:0]  w_e_data;
    memory_data_t w_e_bundle;
    memory_data_t w_nop;

    // Request currently on the bus: live fields in IDLE, latched otherwise.
    logic [63:0]  w_q_addr;
    logic [2:0]   w_q_size;
    logic [7:0]   w_q_strobe;
    logic [63:0]  w_q_data;
    memory_data_t w_q_bundle;
    logic [63:0]  w_lane;
    memory_data_t w_done_bundle;

    assign w_e_is_mem = (dataE.ctl.memread | dataE.ctl.memwrite) & ~dataE.ctl.nop_signal;
    assign w_e_size   = op_size(dataE.ctl.op);
    assign w_e_off    = dataE.result_alu[2:0];
    assign w_e_nbytes = 4'd1 << w_e_size;
    assign w_e_data   = dataE.wd << {w_e_off, 3'b000};

    always_comb begin
        case (w_e_size)
            3'd0:    w_e_aligned = 1'b1;
            3'd1:    w_e_aligned = (w_e_off[0] == 1'b0);
            3'd2:    w_e_aligned = (w_e_off[1:0] == 2'b00);
            default: w_e_aligned = (w_e_off == 3'b000);
        endcase
    end

    // Byte lane gi is written when it falls inside [off, off+nbytes).
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_strobe
            assign w_e_strobe[gi] = dataE.ctl.memwrite
                                  && ({1'b0, w_e_off} <= 4'(gi))
                                  && (4'(gi) < ({1'b0, w_e_off} + w_e_nbytes));
        end
    endgenerate

    assign w_e_bundle = '{pc: dataE.pc, result_alu: dataE.result_alu, wa: dataE.wa, ctl: dataE.ctl};
    assign w_nop      = '{pc: 64'd0, result_alu: 64'd0, wa: 5'd0,
                          ctl: '{op: OP_NOP, regwrite: 1'b0, memwrite: 1'b0,
                                 memread: 1'b0, nop_signal: 1'b1}};

    assign w_q_addr   = (r_state == S_IDLE) ? dataE.result_alu : r_addr;
    assign w_q_size   = (r_state == S_IDLE) ? w_e_size         : r_size;
    assign w_q_strobe = (r_state == S_IDLE) ? w_e_strobe       : r_strobe;
    assign w_q_data   = (r_state == S_IDLE) ? w_e_data         : r_data;
    assign w_q_bundle = (r_state == S_IDLE) ? w_e_bundle       : r_bundle;

    assign w_lane = 64'(dresp_data >> {w_q_addr[2:0], 3'b000});

    // Loads replace result_alu with formatted data; stores keep the address.
    always_comb begin
        w_done_bundle = w_q_bundle;
        if (w_q_bundle.ctl.memread) begin
            w_done_bundle.result_alu = format_load(w_q_bundle.ctl.op, w_lane);
        end
    end

    assign dreq_addr   = w_q_addr[ADDR_W-1:0];
    assign dreq_size   = w_q_size;
    assign dreq_strobe = w_q_strobe;
    assign dreq_data   = w_q_data[DATA_W-1:0];

    always_comb begin
        w_state_next = r_state;
        dataM        = w_e_bundle;
        stallM_req   = 1'b0;
        misalign     = 1'b0;
        dreq_valid   = 1'b0;
        w_capture    = 1'b0;
        w_bundle_we  = 1'b0;
        w_bundle_d   = w_done_bundle;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    dataM = w_nop;
                end else if (w_e_is_mem) begin
                    if (!w_e_aligned) begin
                        misalign                = 1'b1;
                        dataM.ctl.regwrite      = 1'b0;
                        dataM.ctl.memwrite      = 1'b0;
                        dataM.ctl.nop_signal    = 1'b1;
                    end else begin
                        dreq_valid  = 1'b1;
                        w_capture   = 1'b1;
                        w_bundle_we = 1'b1;
                        if (dresp_data_ok) begin
                            dataM = w_done_bundle;
                            if (!advance) begin
                                w_state_next = S_DONE;
                            end
                        end else begin
                            stallM_req   = 1'b1;
                            w_bundle_d   = w_e_bundle;
                            w_state_next = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                dreq_valid = 1'b1;
                dataM      = r_bundle;
                if (flush) begin
                    // The bus cannot drop an accepted request; finish it and discard.
                    dataM = w_nop;
                    if (dresp_data_ok) begin
                        w_state_next = S_IDLE;
                    end else begin
                        stallM_req   = 1'b1;
                        w_state_next = S_DRAIN;
                    end
                end else if (dresp_data_ok) begin
                    dataM = w_done_bundle;
                    if (advance) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_bundle_we  = 1'b1;
                        w_state_next = S_DONE;
                    end
                end else begin
                    stallM_req = 1'b1;
                end
            end
            S_DONE: begin
                // dataE still shows the completed op here, so nothing is reissued.
                dataM = r_bundle;
                if (flush) begin
                    dataM        = w_nop;
                    w_state_next = S_IDLE;
                end else if (advance) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                dreq_valid = 1'b1;
                dataM      = w_nop;
                if (dresp_data_ok) begin
                    w_state_next = S_IDLE;
                end else begin
                    stallM_req = 1'b1;
                end
            end
        endcase
        // Reset outranks everything, including flush and a live mem op.
        if (reset) begin
            dreq_valid  = 1'b0;
            stallM_req  = 1'b0;
            misalign    = 1'b0;
            w_capture   = 1'b0;
            w_bundle_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= 64'd0;
            r_size   <= 3'd0;
            r_strobe <= 8'd0;
            r_data   <= 64'd0;
            r_bundle <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_addr   <= dataE.result_alu;
                r_size   <= w_e_size;
                r_strobe <= w_e_strobe;
                r_data   <= w_e_data;
            end
            if (w_bundle_we) begin
                r_bundle <= w_bundle_d;
            end
        end
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage of the 64-bit in-order pipeline.
- Sits between the execute pipeline register and memory_reg.
- Takes the execute-stage bundle, issues load/store requests on the data bus, and formats load data (sign/zero extension) and store data/strobes.
- Emits the memory_data_t bundle that memory_reg latches.
- Raises a stall request while a bus access is outstanding, and holds completed results until the pipeline advances.

Parameters:
- ADDR_W, 64, data-bus address width.
- DATA_W, 64, data-bus data width (8 byte lanes).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dataE  in  execute_data_t  execute bundle: pc, result_alu (address/ALU result), wd (store data), wa, ctl (op, regwrite, memwrite, memread, nop_signal).
- advance  in  1  pipeline moves this cycle (memory_reg loads, upstream presents next op).
- flush  in  1  squash the current op.
- dataM  out  memory_data_t  bundle to memory_reg; result_alu carries load data for loads.
- stallM_req  out  1  hold the pipeline; drives memory_reg's stallM via the hazard unit.
- misalign  out  1  one-cycle pulse: misaligned access detected.
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  ADDR_W  byte address.
- dreq_size  out  3  0=byte, 1=half, 2=word, 3=double.
- dreq_strobe  out  8  byte-write enables; 0 for loads.
- dreq_data  out  DATA_W  store data, lane-shifted.
- dresp_data_ok  in  1  response/completion for the held request.
- dresp_data  in  DATA_W  raw read data (aligned 8-byte beat).

Behaviour:
- States: IDLE, WAIT, DONE, DRAIN. Reset (sync) → IDLE.
- Reset values:
  - dreq_valid=0, stallM_req=0, misalign=0.
  - Internal held request/result registers = 0.
- Memory op: dataE.ctl.memread|memwrite with nop_signal=0.
- Alignment: addr[0] for half, addr[1:0] for word, addr[2:0] for double must be zero.
- IDLE:
  - No mem op: dataM = dataE pass-through, stallM_req=0.
  - Misaligned mem op: no request, misalign=1 for the cycle, dataM = dataE with regwrite=0, memwrite=0, nop_signal=1, stallM_req=0.
  - Aligned mem op, combinational request:
    - dreq_valid=1; dreq_addr=result_alu.
    - Size from op (LB/LBU/SB=0, LH/LHU/SH=1, LW/LWU/SW=2, LD/SD=3).
    - Strobe = size mask << addr[2:0].
    - dreq_data = wd << 8*addr[2:0].
    - The request is also latched into internal registers.
  - data_ok same cycle and advance → complete, stay IDLE, stallM_req=0.
  - data_ok same cycle, no advance → DONE.
  - No data_ok → WAIT, stallM_req=1.
- WAIT:
  - dreq_valid=1; addr/size/strobe/data driven from latched copy and held stable; stallM_req=1.
  - data_ok + advance → IDLE, stallM_req=0 in that cycle, dataM carries the result.
  - data_ok without advance → DONE.
- DONE:
  - dreq_valid=0, stallM_req=0.
  - dataM driven from the held result.
  - advance → IDLE.
  - Must not reissue even though dataE still shows the same op.
- Load formatting:
  - Lane = dresp_data >> 8*addr[2:0].
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD full.
  - Result replaces dataM.result_alu.
  - Stores: dataM.result_alu = address.
- flush:
  - In IDLE/DONE: no request is issued; dataM becomes the NOP bundle (nop_signal=1, write enables 0, op=NOP); DONE → IDLE.
  - In WAIT: the bus transaction cannot be abandoned → DRAIN.
- DRAIN:
  - dreq_valid=1 held, stallM_req=1.
  - On data_ok: discard result, → IDLE; the next dataM is NOP.
- data_ok arriving in IDLE (no request) or DONE is ignored.
- Reset mid-WAIT: → IDLE next cycle with dreq_valid=0; a late data_ok is ignored.
- Simultaneous reset and flush: reset wins.

Test Plan:
- LD at 0x80001000, dresp_data_ok after 3 cycles with data 0x1122334455667788:
  - dreq_valid high 4 cycles, addr/size=3 stable, stallM_req high 3 cycles.
  - dataM.result_alu=0x1122334455667788.
- LB at 0x80001005, dresp_data=0x0000_80FF_0000_0000, zero-wait with advance:
  - dreq_size=0, strobe=0x00 → result 0xFFFFFFFFFFFFFF80 (lane byte 0x80, sign-extended).
  - LBU of the same gives 0x80.
- SH at 0x80000002, wd=0xABCD:
  - dreq_strobe=0x0C, dreq_data=0x00000000ABCD0000.
  - dataM.ctl.memwrite preserved.
- SW at 0x80000006:
  - misalign pulses once, dreq_valid stays 0.
  - dataM.nop_signal=1, stallM_req=0.
- LW completes with advance=0 for 2 cycles:
  - FSM in DONE, no second dreq_valid, dataM stable.
  - advance → IDLE.
- flush asserted in WAIT:
  - DRAIN holds the request until data_ok, then the NOP bundle is emitted.
- reset asserted in WAIT:
  - dreq_valid=0 the next cycle.
  - A later data_ok does not change dataM.
